// File: rtl/y86_bus_pkg.sv
// Shared types and constants for the y86 two-master memory bus arbiter.
package y86_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;
    localparam int   WAIT_MAX = 7;

endpackage

// File: rtl/y86_bus_arbiter_if.sv
// Bundle of the two master ports and the memory-side port of the y86 bus.
interface y86_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req, m1_req;
    logic          m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_ack, m1_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re, mem_we;
    logic [DW-1:0] mem_rdata;
    logic          grant_id;
    logic          busy;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
        output m0_rdata, m1_rdata, m0_ack, m1_ack, mem_addr, mem_wdata, mem_re, mem_we,
               grant_id, busy
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
        input  m0_rdata, m1_rdata, m0_ack, m1_ack, mem_addr, mem_wdata, mem_re, mem_we,
               grant_id, busy
    );

endinterface

// File: rtl/y86_wait_counter.sv
// Loadable 3-bit down-counter that paces the memory wait states.
module y86_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [2:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_zero = (r_cnt == 3'd0);

endmodule

// File: rtl/y86_bus_arbiter.sv
// Round-robin two-master arbiter and wait-state sequencer for the y86 memory bus.
// state  | meaning
// IDLE   | sample requests, latch the winner's transfer
// ACCESS | memory strobes active for WAIT+1 cycles
// RESP   | one-cycle ack to the winner
module y86_bus_arbiter
    import y86_bus_pkg::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int WAIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    y86_bus_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_RESP   = RESP;
    localparam logic [2:0] WAIT_LD  = (WAIT > WAIT_MAX) ? 3'(WAIT_MAX) : 3'(WAIT);

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic          r_grant_id;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_any_req;
    logic          w_win;
    logic          w_load;
    logic          w_dec;
    logic          w_zero;

    assign w_any_req = bus.m0_req | bus.m1_req;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        w_win = PORT_CPU;
        if (bus.m0_req && bus.m1_req) begin
            w_win = ~r_last_grant;
        end else if (bus.m1_req) begin
            w_win = PORT_AUX;
        end
    end

    assign w_load = (r_state == S_IDLE) && w_any_req;
    assign w_dec  = (r_state == S_ACCESS) && !w_zero;

    y86_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (WAIT_LD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= PORT_AUX;
            r_grant_id   <= PORT_CPU;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_ACCESS;
                        r_last_grant <= w_win;
                        r_grant_id   <= w_win;
                        r_we         <= (w_win == PORT_AUX) ? bus.m1_we    : bus.m0_we;
                        r_addr       <= (w_win == PORT_AUX) ? bus.m1_addr  : bus.m0_addr;
                        r_wdata      <= (w_win == PORT_AUX) ? bus.m1_wdata : bus.m0_wdata;
                    end
                end
                S_ACCESS: begin
                    if (w_zero) begin
                        r_state <= S_RESP;
                        if (!r_we) begin
                            if (r_grant_id == PORT_AUX) begin
                                r_rdata1 <= bus.mem_rdata;
                            end else begin
                                r_rdata0 <= bus.mem_rdata;
                            end
                        end
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_re    = (r_state == S_ACCESS) && !r_we;
    // A write strobes once, in the last wait-state cycle.
    assign bus.mem_we    = (r_state == S_ACCESS) && r_we && w_zero;
    assign bus.m0_ack    = (r_state == S_RESP) && (r_grant_id == PORT_CPU);
    assign bus.m1_ack    = (r_state == S_RESP) && (r_grant_id == PORT_AUX);
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;
    assign bus.grant_id  = r_grant_id;
    assign bus.busy      = (r_state == S_ACCESS) || (r_state == S_RESP);

endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Directed bench: four arbiter instances with WAIT = 0..3 driven from a per-cycle vector table.
module tb_y86_bus_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a      [4];
    logic        m0_req_a   [4];
    logic        m1_req_a   [4];
    logic        m0_we_a    [4];
    logic        m1_we_a    [4];
    logic [31:0] m0_addr_a  [4];
    logic [31:0] m1_addr_a  [4];
    logic [31:0] wdata_a    [4];
    logic [31:0] mem_rdata_a[4];

    logic [3:0]       ack0_a, ack1_a, re_a, we_a, gid_a, busy_a;
    logic [3:0][31:0] rd0_a, rd1_a, maddr_a, mwdata_a;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        y86_bus_arbiter_if #(.AW(32), .DW(32)) bif ();

        assign bif.m0_req    = m0_req_a[g];
        assign bif.m1_req    = m1_req_a[g];
        assign bif.m0_we     = m0_we_a[g];
        assign bif.m1_we     = m1_we_a[g];
        assign bif.m0_addr   = m0_addr_a[g];
        assign bif.m1_addr   = m1_addr_a[g];
        assign bif.m0_wdata  = wdata_a[g];
        assign bif.m1_wdata  = wdata_a[g];
        assign bif.mem_rdata = mem_rdata_a[g];

        assign ack0_a[g]   = bif.m0_ack;
        assign ack1_a[g]   = bif.m1_ack;
        assign re_a[g]     = bif.mem_re;
        assign we_a[g]     = bif.mem_we;
        assign gid_a[g]    = bif.grant_id;
        assign busy_a[g]   = bif.busy;
        assign rd0_a[g]    = bif.m0_rdata;
        assign rd1_a[g]    = bif.m1_rdata;
        assign maddr_a[g]  = bif.mem_addr;
        assign mwdata_a[g] = bif.mem_wdata;

        y86_bus_arbiter #(.AW(32), .DW(32), .WAIT(g)) u_dut (
            .clk (clk),
            .rst (rst_a[g]),
            .bus (bif)
        );
    end

    typedef struct {
        int          inst;
        bit          rst;
        bit [1:0]    m0;     // {req, we}
        logic [31:0] a0;
        bit [1:0]    m1;
        logic [31:0] a1;
        logic [31:0] wd;
        logic [31:0] mrd;
        bit [5:0]    fl;     // {ack0, ack1, mem_re, mem_we, grant_id, busy}
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t v(int inst, bit rst, bit [1:0] m0, logic [31:0] a0, bit [1:0] m1,
                               logic [31:0] a1, logic [31:0] wd, logic [31:0] mrd, bit [5:0] fl,
                               logic [31:0] maddr, logic [31:0] mwd, logic [31:0] rd0,
                               logic [31:0] rd1);
        vec_t r;
        r.inst = inst; r.rst = rst; r.m0 = m0; r.a0 = a0; r.m1 = m1; r.a1 = a1;
        r.wd = wd; r.mrd = mrd; r.fl = fl; r.maddr = maddr; r.mwd = mwd;
        r.rd0 = rd0; r.rd1 = rd1;
        return r;
    endfunction

    function automatic logic [31:0] flags(int k);
        return {26'd0, ack0_a[k], ack1_a[k], re_a[k], we_a[k], gid_a[k], busy_a[k]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t r);
        for (int k = 0; k < 4; k++) rst_a[k] = 1'b0;
        rst_a[r.inst]       = r.rst;
        m0_req_a[r.inst]    = r.m0[1];
        m0_we_a[r.inst]     = r.m0[0];
        m0_addr_a[r.inst]   = r.a0;
        m1_req_a[r.inst]    = r.m1[1];
        m1_we_a[r.inst]     = r.m1[0];
        m1_addr_a[r.inst]   = r.a1;
        wdata_a[r.inst]     = r.wd;
        mem_rdata_a[r.inst] = r.mrd;
    endtask

    initial begin
        int  cyc, last_cyc, n0, n1;
        bit  got;

        for (int k = 0; k < 4; k++) begin
            rst_a[k] = 1'b1; m0_req_a[k] = 1'b0; m1_req_a[k] = 1'b0;
            m0_we_a[k] = 1'b0; m1_we_a[k] = 1'b0; m0_addr_a[k] = '0; m1_addr_a[k] = '0;
            wdata_a[k] = '0; mem_rdata_a[k] = '0;
        end

        // WAIT=1 read of 0x10; rdata must come from the last ACCESS cycle only
        tbl.push_back(v(1, 0, 2'b10, 32'h10, 2'b00, 0, 0, 32'h0,        6'b000000, 32'h0,  0, 0, 0));
        tbl.push_back(v(1, 0, 2'b10, 32'h10, 2'b00, 0, 0, 32'h11111111, 6'b001001, 32'h10, 0, 0, 0));
        tbl.push_back(v(1, 0, 2'b10, 32'h10, 2'b00, 0, 0, 32'hDEADBEEF, 6'b001001, 32'h10, 0, 0, 0));
        tbl.push_back(v(1, 0, 2'b10, 32'h10, 2'b00, 0, 0, 32'h0,        6'b100001, 32'h10, 0, 32'hDEADBEEF, 0));
        tbl.push_back(v(1, 0, 2'b00, 32'h0,  2'b00, 0, 0, 32'h0,        6'b000000, 32'h10, 0, 32'hDEADBEEF, 0));
        // WAIT=1 read of 0x8 with the master address changing mid-transfer
        tbl.push_back(v(1, 0, 2'b10, 32'h8,  2'b00, 0, 0, 32'h0,        6'b000000, 32'h10, 0, 32'hDEADBEEF, 0));
        tbl.push_back(v(1, 0, 2'b10, 32'hC,  2'b00, 0, 0, 32'h0,        6'b001001, 32'h8,  0, 32'hDEADBEEF, 0));
        tbl.push_back(v(1, 0, 2'b10, 32'hC,  2'b00, 0, 0, 32'h0C0C0C0C, 6'b001001, 32'h8,  0, 32'hDEADBEEF, 0));
        tbl.push_back(v(1, 0, 2'b10, 32'hC,  2'b00, 0, 0, 32'h0,        6'b100001, 32'h8,  0, 32'h0C0C0C0C, 0));
        tbl.push_back(v(1, 0, 2'b00, 32'h0,  2'b00, 0, 0, 32'h0,        6'b000000, 32'h8,  0, 32'h0C0C0C0C, 0));
        // WAIT=2 write of 0x55AA to 0x20 from m1
        tbl.push_back(v(2, 0, 2'b00, 0, 2'b11, 32'h20, 32'h55AA, 32'h0,        6'b000000, 32'h0,  32'h0,    0, 0));
        tbl.push_back(v(2, 0, 2'b00, 0, 2'b11, 32'h20, 32'h55AA, 32'h12345678, 6'b000011, 32'h20, 32'h55AA, 0, 0));
        tbl.push_back(v(2, 0, 2'b00, 0, 2'b11, 32'h20, 32'h55AA, 32'h12345678, 6'b000011, 32'h20, 32'h55AA, 0, 0));
        tbl.push_back(v(2, 0, 2'b00, 0, 2'b11, 32'h20, 32'h55AA, 32'h12345678, 6'b000111, 32'h20, 32'h55AA, 0, 0));
        tbl.push_back(v(2, 0, 2'b00, 0, 2'b11, 32'h20, 32'h55AA, 32'h0,        6'b010011, 32'h20, 32'h55AA, 0, 0));
        tbl.push_back(v(2, 0, 2'b00, 0, 2'b00, 32'h0,  32'h0,    32'h0,        6'b000010, 32'h20, 32'h55AA, 0, 0));
        // WAIT=0 back-to-back m0 reads of 0x0 and 0x4
        tbl.push_back(v(0, 0, 2'b10, 32'h0, 2'b00, 0, 0, 32'h0,        6'b000000, 32'h0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 2'b10, 32'h0, 2'b00, 0, 0, 32'hA0A0A0A0, 6'b001001, 32'h0, 0, 32'h0,        0));
        tbl.push_back(v(0, 0, 2'b10, 32'h0, 2'b00, 0, 0, 32'h0,        6'b100001, 32'h0, 0, 32'hA0A0A0A0, 0));
        tbl.push_back(v(0, 0, 2'b10, 32'h4, 2'b00, 0, 0, 32'h0,        6'b000000, 32'h0, 0, 32'hA0A0A0A0, 0));
        tbl.push_back(v(0, 0, 2'b10, 32'h4, 2'b00, 0, 0, 32'hB4B4B4B4, 6'b001001, 32'h4, 0, 32'hA0A0A0A0, 0));
        tbl.push_back(v(0, 0, 2'b10, 32'h4, 2'b00, 0, 0, 32'h0,        6'b100001, 32'h4, 0, 32'hB4B4B4B4, 0));
        tbl.push_back(v(0, 0, 2'b00, 32'h0, 2'b00, 0, 0, 32'h0,        6'b000000, 32'h4, 0, 32'hB4B4B4B4, 0));
        // WAIT=3 m1 write aborted by rst in its 2nd ACCESS cycle
        tbl.push_back(v(3, 0, 2'b00, 0, 2'b11, 32'h40, 32'h77, 0, 6'b000000, 32'h0,  32'h0,  0, 0));
        tbl.push_back(v(3, 0, 2'b00, 0, 2'b11, 32'h40, 32'h77, 0, 6'b000011, 32'h40, 32'h77, 0, 0));
        tbl.push_back(v(3, 1, 2'b00, 0, 2'b11, 32'h40, 32'h77, 0, 6'b000011, 32'h40, 32'h77, 0, 0));
        tbl.push_back(v(3, 0, 2'b00, 0, 2'b00, 32'h0,  32'h0,  0, 6'b000000, 32'h0,  32'h0,  0, 0));
        tbl.push_back(v(3, 0, 2'b00, 0, 2'b00, 32'h0,  32'h0,  0, 6'b000000, 32'h0,  32'h0,  0, 0));
        tbl.push_back(v(3, 0, 2'b00, 0, 2'b00, 32'h0,  32'h0,  0, 6'b000000, 32'h0,  32'h0,  0, 0));
        tbl.push_back(v(3, 0, 2'b00, 0, 2'b00, 32'h0,  32'h0,  0, 6'b000000, 32'h0,  32'h0,  0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset[%0d] flags", k),  flags(k),    32'h0);
            chk($sformatf("reset[%0d] mem_addr", k), maddr_a[k],  32'h0);
            chk($sformatf("reset[%0d] mem_wdata", k), mwdata_a[k], 32'h0);
            chk($sformatf("reset[%0d] m0_rdata", k), rd0_a[k],    32'h0);
            chk($sformatf("reset[%0d] m1_rdata", k), rd1_a[k],    32'h0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d flags", i),     flags(tbl[i].inst),       {26'd0, tbl[i].fl});
            chk($sformatf("row%0d mem_addr", i),  maddr_a[tbl[i].inst],     tbl[i].maddr);
            chk($sformatf("row%0d mem_wdata", i), mwdata_a[tbl[i].inst],    tbl[i].mwd);
            chk($sformatf("row%0d m0_rdata", i),  rd0_a[tbl[i].inst],       tbl[i].rd0);
            chk($sformatf("row%0d m1_rdata", i),  rd1_a[tbl[i].inst],       tbl[i].rd1);
        end

        // Round-robin after reset: both masters hold reads on the WAIT=1 instance
        @(posedge clk);
        #1;
        rst_a[1] = 1'b1;
        @(posedge clk);
        #1;
        rst_a[1] = 1'b0;
        m0_req_a[1] = 1'b1; m0_we_a[1] = 1'b0; m0_addr_a[1] = 32'h100;
        m1_req_a[1] = 1'b1; m1_we_a[1] = 1'b0; m1_addr_a[1] = 32'h200;
        mem_rdata_a[1] = 32'hCAFE0000;
        cyc = 0; last_cyc = 0; n0 = 0; n1 = 0;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                cyc++;
                if (ack0_a[1] || ack1_a[1]) begin
                    got = 1'b1;
                    n0 += int'(ack0_a[1]);
                    n1 += int'(ack1_a[1]);
                    chk($sformatf("arb%0d ack pair", t), {30'd0, ack0_a[1], ack1_a[1]},
                        (t % 2 == 0) ? 32'd2 : 32'd1);
                    chk($sformatf("arb%0d grant_id", t), {31'd0, gid_a[1]}, 32'(t % 2));
                    if (t > 0) chk($sformatf("arb%0d spacing", t), 32'(cyc - last_cyc), 32'd4);
                    else       chk("arb0 latency", 32'(cyc), 32'd4);
                    last_cyc = cyc;
                end
            end
            if (!got) chk($sformatf("arb%0d ack timeout", t), 32'd0, 32'd1);
        end
        chk("arb m0 ack count", 32'(n0), 32'd2);
        chk("arb m1 ack count", 32'(n1), 32'd2);
        chk("arb m0_rdata", rd0_a[1], 32'hCAFE0000);
        chk("arb m1_rdata", rd1_a[1], 32'hCAFE0000);
        @(posedge clk);
        #1;
        m0_req_a[1] = 1'b0;
        m1_req_a[1] = 1'b0;

        // m1 drops req right after being sampled; the read still completes and acks
        @(posedge clk);
        #1;
        m1_req_a[0] = 1'b1; m1_we_a[0] = 1'b0; m1_addr_a[0] = 32'h300;
        mem_rdata_a[0] = 32'h3C3C3C3C;
        @(negedge clk);
        chk("drop idle flags", flags(0), 32'h0);
        @(posedge clk);
        #1;
        m1_req_a[0] = 1'b0;
        @(negedge clk);
        chk("drop access flags", flags(0), 32'b001011);
        chk("drop access addr",  maddr_a[0], 32'h300);
        @(posedge clk);
        #1;
        mem_rdata_a[0] = 32'h0;
        @(negedge clk);
        chk("drop resp flags", flags(0), 32'b010011);
        chk("drop m1_rdata",   rd1_a[0], 32'h3C3C3C3C);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drop idle after", flags(0), 32'b000010);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
